// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    // E-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Data-memory wait sequencer states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ABORT
    } mem_state_t;

    // M-stage result is younger than W, so it wins when both match.
    function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_M;
        end
        if (hit_w) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Freezes the pipeline while data memory is busy; aborts an access that
// outlives MEM_TIMEOUT wait cycles and latches a sticky error.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req_m,
    input  logic mem_ready,
    output logic mem_stall,
    output logic abort,
    output logic mem_timeout_err
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

    mem_state_t      state;
    logic [CntW-1:0] wait_cnt;

    // State, wait counter and sticky timeout error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_m && !mem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= CntW'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CntMax) begin
                        state           <= ABORT;
                        wait_cnt        <= '0;
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CntW'(1);
                    end
                end
                // mem_ready is ignored here; the access is already dead
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Stall is combinational so a same-cycle mem_ready never costs a cycle
    always_comb begin
        mem_stall = ((state == IDLE) && mem_req_m && !mem_ready) ||
                    ((state == WAIT) && !mem_ready && (wait_cnt < CntMax));
        abort     = (state == ABORT);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage core: forwarding,
// load-use / PC-write / branch hazards, memory-wait freeze and stall counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  ra1_d,
    input  logic [REG_W-1:0]  ra2_d,
    input  logic [REG_W-1:0]  ra1_e,
    input  logic [REG_W-1:0]  ra2_e,
    input  logic [REG_W-1:0]  wa3_e,
    input  logic [REG_W-1:0]  wa3_m,
    input  logic [REG_W-1:0]  wa3_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              mem_to_reg_e,
    input  logic              pc_src_d,
    input  logic              pc_src_e,
    input  logic              pc_src_m,
    input  logic              pc_src_w,
    input  logic              branch_taken_e,
    input  logic              mem_req_m,
    input  logic              mem_ready,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              mem_timeout_err,
    output logic [PERF_W-1:0] stall_cycles
);

    logic mem_stall;
    logic abort;
    logic ldr_stall;
    logic pc_pend;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk            (clk),
        .reset          (reset),
        .mem_req_m      (mem_req_m),
        .mem_ready      (mem_ready),
        .mem_stall      (mem_stall),
        .abort          (abort),
        .mem_timeout_err(mem_timeout_err)
    );

    // Hazard detection terms
    always_comb begin
        ldr_stall = mem_to_reg_e && ((ra1_d == wa3_e) || (ra2_d == wa3_e));
        pc_pend   = pc_src_d || pc_src_e || pc_src_m;
    end

    // Stall/flush/forward resolution; memory freeze outranks every hazard
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        if (!reset) begin
            forward_a_e = fwd_pick((ra1_e == wa3_m) && reg_write_m,
                                   (ra1_e == wa3_w) && reg_write_w);
            forward_b_e = fwd_pick((ra2_e == wa3_m) && reg_write_m,
                                   (ra2_e == wa3_w) && reg_write_w);
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                // During abort the pipeline must advance past the dead access
                stall_f = !abort && (ldr_stall || pc_pend);
                stall_d = !abort && ldr_stall;
                flush_d = pc_pend || pc_src_w || branch_taken_e;
                flush_e = ldr_stall || branch_taken_e;
                flush_w = abort;
            end
        end
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_f && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// memory-wait sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int TO       = 15;
    localparam int PERF_MAX = 65535;

    typedef struct packed {
        logic [3:0] ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
        logic reg_write_m, reg_write_w, mem_to_reg_e;
        logic pc_src_d, pc_src_e, pc_src_m, pc_src_w, branch_taken_e;
        logic mem_req_m, mem_ready;
    } in_t;

    // exp = {fwd_a[1:0], fwd_b[1:0], sf, sd, se, sm, fd, fe, fw}
    typedef struct {
        in_t        in;
        logic [10:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    in_t         cur;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;
    logic        mem_timeout_err;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: age of the outstanding access (0 = none), abort cycle flag
    int m_age;
    bit m_abort;
    bit m_err;
    int m_cnt;

    vec_t vecs[10];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_W      (4),
        .MEM_TIMEOUT(TO),
        .PERF_W     (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ra1_d          (cur.ra1_d),
        .ra2_d          (cur.ra2_d),
        .ra1_e          (cur.ra1_e),
        .ra2_e          (cur.ra2_e),
        .wa3_e          (cur.wa3_e),
        .wa3_m          (cur.wa3_m),
        .wa3_w          (cur.wa3_w),
        .reg_write_m    (cur.reg_write_m),
        .reg_write_w    (cur.reg_write_w),
        .mem_to_reg_e   (cur.mem_to_reg_e),
        .pc_src_d       (cur.pc_src_d),
        .pc_src_e       (cur.pc_src_e),
        .pc_src_m       (cur.pc_src_m),
        .pc_src_w       (cur.pc_src_w),
        .branch_taken_e (cur.branch_taken_e),
        .mem_req_m      (cur.mem_req_m),
        .mem_ready      (cur.mem_ready),
        .forward_a_e    (forward_a_e),
        .forward_b_e    (forward_b_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_w        (flush_w),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles   (stall_cycles)
    );

    function automatic logic [10:0] outs();
        return {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
                flush_d, flush_e, flush_w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [3:0] ra, input in_t v);
        if (v.reg_write_m && ra == v.wa3_m) return 2'd2;
        if (v.reg_write_w && ra == v.wa3_w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [10:0] model_out(input in_t v, input bit rst);
        logic [1:0] fa, fb;
        bit ldr, pcp, freeze, sf, sd, fd, fe;
        if (rst) return '0;
        fa  = fwd_of(v.ra1_e, v);
        fb  = fwd_of(v.ra2_e, v);
        ldr = v.mem_to_reg_e && (v.ra1_d == v.wa3_e || v.ra2_d == v.wa3_e);
        pcp = v.pc_src_d || v.pc_src_e || v.pc_src_m;
        if (m_abort)         freeze = 0;
        else if (m_age == 0) freeze = v.mem_req_m && !v.mem_ready;
        else                 freeze = !v.mem_ready && m_age < TO;
        if (freeze) return {fa, fb, 4'b1111, 3'b001};
        sf = !m_abort && (ldr || pcp);
        sd = !m_abort && ldr;
        fd = pcp || v.pc_src_w || v.branch_taken_e;
        fe = ldr || v.branch_taken_e;
        return {fa, fb, sf, sd, 2'b00, fd, fe, m_abort};
    endfunction

    task automatic model_clear();
        m_age = 0; m_abort = 0; m_err = 0; m_cnt = 0;
    endtask

    // Advance the model on the current inputs, then cross one clock edge
    task automatic tick();
        logic [10:0] o;
        o = model_out(cur, reset);
        if (reset) begin
            model_clear();
        end else begin
            if (o[6] && m_cnt < PERF_MAX) m_cnt++;
            if (m_abort) begin
                m_abort = 0;
            end else if (m_age == 0) begin
                if (cur.mem_req_m && !cur.mem_ready) m_age = 1;
            end else if (cur.mem_ready) begin
                m_age = 0;
            end else if (m_age == TO) begin
                m_age = 0; m_abort = 1; m_err = 1;
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cur   = '0;
        reset = 1'b1;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 10; i++) vecs[i].in = '0;
        vecs[0].in.ra1_e = 3; vecs[0].in.wa3_m = 3; vecs[0].in.reg_write_m = 1;
        vecs[0].in.wa3_w = 3; vecs[0].in.reg_write_w = 1;
        vecs[0].exp = 11'b10_00_0000_000;
        vecs[1].in = vecs[0].in; vecs[1].in.reg_write_m = 0;
        vecs[1].exp = 11'b01_00_0000_000;
        vecs[2].in.ra2_e = 7; vecs[2].in.wa3_m = 7; vecs[2].in.reg_write_m = 1;
        vecs[2].exp = 11'b00_10_0000_000;
        vecs[3].in.mem_to_reg_e = 1; vecs[3].in.wa3_e = 5; vecs[3].in.ra2_d = 5;
        vecs[3].exp = 11'b00_00_1100_010;
        vecs[4].in.mem_to_reg_e = 1; vecs[4].in.wa3_e = 5; vecs[4].in.ra2_d = 6;
        vecs[4].in.ra1_d = 1;
        vecs[4].exp = 11'b00_00_0000_000;
        vecs[5].in.branch_taken_e = 1; vecs[5].in.pc_src_e = 1;
        vecs[5].exp = 11'b00_00_1000_110;
        vecs[6].in.pc_src_w = 1;
        vecs[6].exp = 11'b00_00_0000_100;
        vecs[7].in.pc_src_m = 1;
        vecs[7].exp = 11'b00_00_1000_100;
        vecs[8].in.pc_src_d = 1; vecs[8].in.mem_to_reg_e = 1; vecs[8].in.wa3_e = 9;
        vecs[8].in.ra1_d = 9;
        vecs[8].exp = 11'b00_00_1100_110;
        vecs[9].in.mem_req_m = 1; vecs[9].in.mem_ready = 1;
        vecs[9].exp = 11'b00_00_0000_000;

        // Reset state: outputs forced low even with a forwarding match present
        cur   = vecs[0].in;
        reset = 1'b1;
        model_clear();
        #2;
        check("reset_outs", 32'(outs()), 32'd0);
        tick();
        check("reset_err", 32'(mem_timeout_err), 32'd0);
        check("reset_cnt", 32'(stall_cycles), 32'd0);
        reset = 1'b0;

        // Directed combinational vectors with the memory sequencer idle
        for (int i = 0; i < 10; i++) begin
            cur = vecs[i].in;
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            tick();
        end

        // Three-cycle memory wait
        do_reset();
        cur = '0; cur.mem_req_m = 1;
        for (int k = 0; k < 3; k++) begin
            #1; check($sformatf("wait_stall%0d", k), 32'(outs()), 32'b00_00_1111_001);
            tick();
        end
        cur.mem_ready = 1;
        #1; check("wait_done", 32'(outs()), 32'd0);
        tick();
        cur = '0;
        #1; check("wait_cnt", 32'(stall_cycles), 32'd3);
        check("wait_err", 32'(mem_timeout_err), 32'd0);
        tick();

        // Timeout: stalls, then an unstalled final wait cycle, then the abort cycle
        do_reset();
        cur = '0; cur.mem_req_m = 1;
        for (int k = 0; k < TO; k++) begin
            #1; check($sformatf("to_stall%0d", k), 32'(outs()), 32'b00_00_1111_001);
            tick();
        end
        #1; check("to_last_wait", 32'(outs()), 32'd0);
        tick();
        cur.mem_ready = 1;
        #1; check("to_abort", 32'(outs()), 32'b00_00_0000_001);
        check("to_err_set", 32'(mem_timeout_err), 32'd1);
        tick();
        cur = '0;
        #1; check("to_after", 32'(outs()), 32'd0);
        check("to_cnt", 32'(stall_cycles), 32'(TO));
        repeat (3) tick();
        check("to_err_sticky", 32'(mem_timeout_err), 32'd1);

        // Reset in the middle of a wait
        do_reset();
        cur = '0; cur.mem_req_m = 1;
        tick();
        tick();
        cur.ra1_e = 3; cur.wa3_m = 3; cur.reg_write_m = 1;
        #1; check("mid_stall", 32'(outs()), 32'b10_00_1111_001);
        reset = 1'b1;
        model_clear();
        #1; check("mid_rst_outs", 32'(outs()), 32'd0);
        check("mid_rst_cnt", 32'(stall_cycles), 32'd0);
        check("mid_rst_err", 32'(mem_timeout_err), 32'd0);
        tick();
        reset = 1'b0;
        cur.mem_ready = 1;
        #1; check("mid_release", 32'(outs()), 32'b10_00_0000_000);
        tick();
        check("mid_release_cnt", 32'(stall_cycles), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cur.ra1_d          = 4'($urandom_range(0, 3));
            cur.ra2_d          = 4'($urandom_range(0, 3));
            cur.ra1_e          = 4'($urandom_range(0, 3));
            cur.ra2_e          = 4'($urandom_range(0, 3));
            cur.wa3_e          = 4'($urandom_range(0, 3));
            cur.wa3_m          = 4'($urandom_range(0, 3));
            cur.wa3_w          = 4'($urandom_range(0, 3));
            cur.reg_write_m    = 1'($urandom_range(0, 1));
            cur.reg_write_w    = 1'($urandom_range(0, 1));
            cur.mem_to_reg_e   = ($urandom_range(0, 2) == 0);
            cur.pc_src_d       = ($urandom_range(0, 5) == 0);
            cur.pc_src_e       = ($urandom_range(0, 5) == 0);
            cur.pc_src_m       = ($urandom_range(0, 5) == 0);
            cur.pc_src_w       = ($urandom_range(0, 5) == 0);
            cur.branch_taken_e = ($urandom_range(0, 5) == 0);
            cur.mem_req_m      = ($urandom_range(0, 2) == 0);
            cur.mem_ready      = ($urandom_range(0, 7) < 3);
            #1;
            check("rand_outs", 32'(outs()), 32'(model_out(cur, 1'b0)));
            check("rand_err", 32'(mem_timeout_err), 32'(m_err));
            check("rand_cnt", 32'(stall_cycles), 32'(m_cnt));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipelined ARM core. It drives the enable/clear controls of the F, D, E, M and W pipeline registers and the E-stage forwarding muxes. It resolves load-use, PC-write and branch hazards, and adds a sequential memory-wait FSM that freezes the pipeline while data memory is not ready, with a timeout that aborts the access. Saturating stall-cycle and timeout-error status are exported for debug.

## Interface
Parameters:
- REG_W, 4, register address width
- MEM_TIMEOUT, 15, maximum wait cycles for one M-stage access before abort (≥2)
- PERF_W, 16, stall-cycle counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ra1_d, ra2_d  in  REG_W  source registers of instruction in D
- ra1_e, ra2_e  in  REG_W  source registers of instruction in E
- wa3_e, wa3_m, wa3_w  in  REG_W  destination register in E/M/W
- reg_write_m, reg_write_w  in  1  M/W instruction writes the register file
- mem_to_reg_e  in  1  E instruction is a load
- pc_src_d, pc_src_e, pc_src_m, pc_src_w  in  1  instruction in that stage writes PC
- branch_taken_e  in  1  branch resolved taken in E
- mem_req_m  in  1  load/store in M
- mem_ready  in  1  data memory completes access this cycle
- forward_a_e, forward_b_e  out  2  00 = regfile, 01 = W result, 10 = M ALU result
- stall_f, stall_d, stall_e, stall_m  out  1  hold the register feeding that stage (en = ~stall)
- flush_d, flush_e, flush_w  out  1  clear the register feeding that stage
- mem_timeout_err  out  1  sticky: an access was aborted
- stall_cycles  out  PERF_W  saturating count of cycles with stall_f = 1

## Operation
- Forwarding, per operand X∈{a,b}: 10 if ra_x_e == wa3_m && reg_write_m; else 01 if ra_x_e == wa3_w && reg_write_w; else 00. M has priority over W.
- ldr_stall = mem_to_reg_e && (ra1_d == wa3_e || ra2_d == wa3_e).
- pc_pend = pc_src_d | pc_src_e | pc_src_m.
- Memory FSM states:
  - IDLE: mem_req_m && !mem_ready → WAIT, wait_cnt = 1.
  - WAIT: mem_ready → IDLE. Else if wait_cnt == MEM_TIMEOUT → ABORT and set mem_timeout_err. Else wait_cnt + 1.
  - ABORT: one cycle, then → IDLE unconditionally.
- mem_stall = (IDLE && mem_req_m && !mem_ready) || (WAIT && !mem_ready && wait_cnt < MEM_TIMEOUT).
- Priority 1, mem_stall = 1:
  - stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1 (bubble into W).
  - flush_d = flush_e = 0.
  - Forwarding still computed.
- Priority 2, ABORT: no stalls; flush_w = 1 (squashes the failed access); hazard terms below still apply.
- Otherwise:
  - stall_f = ldr_stall | pc_pend; stall_d = ldr_stall; stall_e = stall_m = 0.
  - flush_d = pc_pend | pc_src_w | branch_taken_e.
  - flush_e = ldr_stall | branch_taken_e.
  - flush_w = 0.
- stall_cycles increments each cycle stall_f = 1 and saturates at all-ones.

## Timing
- Stall/flush/forward outputs are combinational from inputs and FSM state, with zero latency. mem_ready arriving in the same cycle as the request causes no stall.
- Wait stalls last exactly until the cycle mem_ready is seen. The maximum is MEM_TIMEOUT stalled cycles, then one ABORT cycle.
- mem_ready in the same cycle that wait_cnt == MEM_TIMEOUT counts as completion: → IDLE, no error.
- mem_ready during ABORT is ignored.
- Reset (asynchronous, any state, including mid-WAIT):
  - FSM → IDLE, wait_cnt = 0, mem_timeout_err = 0, stall_cycles = 0.
  - While reset = 1, all stall, flush and forward outputs are forced to 0.
- mem_timeout_err is cleared only by reset.

## Structure
- Package pipe_ctrl_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - mem_state_t enum: IDLE, WAIT, ABORT.
- Sub-module mem_wait_fsm holds the state, wait_cnt (width $clog2(MEM_TIMEOUT+1)) and the sticky error. It outputs mem_stall, abort and mem_timeout_err.
- The top level holds the forwarding/hazard logic and the perf counter.

## Test plan
- ra1_e = 3, wa3_m = 3, reg_write_m = 1, wa3_w = 3, reg_write_w = 1 → forward_a_e = 10. Drop reg_write_m → 01.
- mem_to_reg_e = 1, wa3_e = 5, ra2_d = 5 → stall_f = stall_d = flush_e = 1, flush_d = 0. Next cycle with mem_to_reg_e = 0 → all 0.
- branch_taken_e = 1 with pc_src_e = 1 → flush_d = flush_e = 1, stall_f = 1.
- mem_req_m = 1, mem_ready low for 3 cycles then high → exactly 3 cycles of stall_f..stall_m = flush_w = 1; stall_cycles = 3; err = 0.
- mem_ready never asserted, MEM_TIMEOUT = 15 → 15 stall cycles, then one cycle of flush_w = 1 with no stall; mem_timeout_err = 1 stays high.
- Reset asserted in cycle 2 of a wait → outputs 0 immediately, FSM IDLE, counters 0. After release with mem_ready = 1 → no stall.
